// File: rtl/mau_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mau_pkg                                                         |
// | Purpose  : Shared size encodings, FSM state type and defaults for the      |
// |            memory access unit.                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mau_pkg;

   localparam int         c_DEF_ADDR_W = 5;

   localparam logic [1:0] c_SZ_B = 2'b00;
   localparam logic [1:0] c_SZ_H = 2'b01;
   localparam logic [1:0] c_SZ_W = 2'b10;
   localparam logic [1:0] c_SZ_R = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } mauState_t;

endpackage
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mau_lane_align                                                  |
// | Purpose  : Little-endian lane extraction for loads and lane merge for      |
// |            sub-word stores.                                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_byteOff,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_wData,
   output logic [31:0] o_loadVal,
   output logic [31:0] o_storeWord
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_byteOff, 3'b000} +: 8];
   assign w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_loadVal   = i_word;
      o_storeWord = i_wData;
      case (i_size)
         c_SZ_B: begin
            o_loadVal   = {{24{i_signed & w_byte[7]}}, w_byte};
            o_storeWord = i_word;
            o_storeWord[{i_byteOff, 3'b000} +: 8] = i_wData[7:0];
         end
         c_SZ_H: begin
            o_loadVal   = {{16{i_signed & w_half[15]}}, w_half};
            o_storeWord = i_byteOff[1] ? {i_wData[15:0], i_word[15:0]}
                                       : {i_word[31:16], i_wData[15:0]};
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : MA-stage initiator turning byte-addressed loads/stores into     |
// |            word reads, writes and read-modify-writes.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W  = c_DEF_ADDR_W,
   parameter int RD_WAIT = 0
)(
   input  logic        clkIn,
   input  logic        resetIn,
   input  logic        ReqValidIn,
   output logic        ReqReadyOut,
   input  logic [31:0] AddrIn,
   input  logic [31:0] WDataIn,
   input  logic        LoadIn,
   input  logic        StoreIn,
   input  logic [1:0]  SizeIn,
   input  logic        SignedIn,
   output logic [31:0] MemAddrOut,
   output logic [31:0] MemDataOut,
   output logic        MemReadOut,
   output logic        MemWriteOut,
   input  logic [31:0] MemDataIn,
   output logic [31:0] RDataOut,
   output logic        RValidOut,
   output logic        ErrOut,
   output logic        StallOut
);

   localparam int                  c_WAIT_W    = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(RD_WAIT);

   mauState_t           r_state, w_nextState;
   logic [ADDR_W-1:0]   r_wordIdx;
   logic [1:0]          r_byteOff, r_size;
   logic                r_signed, r_isLoad, r_isErr;
   logic [31:0]         r_wData, r_rdWord, r_rData;
   logic [c_WAIT_W-1:0] r_waitCnt;
   logic                w_accept, w_reqErr, w_waitDone, w_strobe, w_unused;
   logic [31:0]         w_alignWord, w_loadVal, w_storeWord;

   assign w_accept   = ReqValidIn & (LoadIn | StoreIn);
   assign w_reqErr   = (SizeIn == c_SZ_R) | (LoadIn & StoreIn)
                     | ((SizeIn == c_SZ_H) & AddrIn[0])
                     | ((SizeIn == c_SZ_W) & (|AddrIn[1:0]));
   assign w_waitDone = (r_waitCnt == c_WAIT_LAST);
   assign w_unused   = ^AddrIn[31:ADDR_W+2];

   // Loads extract straight from the bus; RMW merges into the word held from RD.
   assign w_alignWord = (r_state == ST_RD) ? MemDataIn : r_rdWord;

   mau_lane_align u_laneAlign (
      .i_word      (w_alignWord),
      .i_byteOff   (r_byteOff),
      .i_size      (r_size),
      .i_signed    (r_signed),
      .i_wData     (r_wData),
      .o_loadVal   (w_loadVal),
      .o_storeWord (w_storeWord)
   );

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) r_state <= ST_IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_reqErr)              w_nextState = ST_RESP;
               else if (LoadIn)           w_nextState = ST_RD;
               else if (SizeIn == c_SZ_W) w_nextState = ST_WR;
               else                       w_nextState = ST_RD;
            end
         end
         ST_RD:   if (w_waitDone) w_nextState = r_isLoad ? ST_RESP : ST_WR;
         ST_WR:   w_nextState = ST_RESP;
         ST_RESP: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         r_wordIdx <= '0;
         r_byteOff <= '0;
         r_size    <= '0;
         r_signed  <= 1'b0;
         r_isLoad  <= 1'b0;
         r_isErr   <= 1'b0;
         r_wData   <= '0;
         r_rdWord  <= '0;
         r_rData   <= '0;
         r_waitCnt <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_accept) begin
            r_wordIdx <= AddrIn[ADDR_W+1:2];
            r_byteOff <= AddrIn[1:0];
            r_size    <= SizeIn;
            r_signed  <= SignedIn;
            r_wData   <= WDataIn;
            r_isLoad  <= LoadIn;
            r_isErr   <= w_reqErr;
            r_waitCnt <= '0;
         end
         if (r_state == ST_RD) begin
            r_waitCnt <= r_waitCnt + 1'b1;
            if (w_waitDone) r_rdWord <= MemDataIn;
         end
         // Result register only changes on entry to RESP, so it holds in between.
         if ((w_nextState == ST_RESP) && (r_state != ST_RESP))
            r_rData <= (r_state == ST_RD) ? w_loadVal : '0;
      end
   end

   assign w_strobe    = (r_state == ST_RD) | (r_state == ST_WR);
   assign ReqReadyOut = (r_state == ST_IDLE);
   assign StallOut    = ((r_state == ST_IDLE) & w_accept) | w_strobe;
   assign MemReadOut  = (r_state == ST_RD);
   assign MemWriteOut = (r_state == ST_WR);
   assign MemAddrOut  = w_strobe ? {{(32-ADDR_W){1'b0}}, r_wordIdx} : '0;
   assign MemDataOut  = (r_state == ST_WR) ? w_storeWord : '0;
   assign RDataOut    = r_rData;
   assign RValidOut   = (r_state == ST_RESP);
   assign ErrOut      = (r_state == ST_RESP) & r_isErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                              |
// | Purpose  : Self-checking bench, byte-array reference model, two DUTs       |
// |            (RD_WAIT=0 and RD_WAIT=2).                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

   typedef struct packed {
      int          lat;
      int          rdc;
      int          wrc;
      int          stallc;
      logic [31:0] rdata;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic        err;
      logic        ready0;
   } res_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        memInit;
   logic [31:0] addr, wd;
   logic        ld, st, sg;
   logic [1:0]  sz;
   logic        valid [2];
   logic        ready [2], stall [2], memRd [2], memWr [2], rvld [2], errO [2];
   logic [31:0] memAddr [2], memDO [2], memDI [2], rdata [2];
   logic [31:0] ram [2][32];
   logic [7:0]  refB [2][128];
   int          rdRun = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(5), .RD_WAIT(0)) u_dut0 (
      .clkIn(clk), .resetIn(rstN), .ReqValidIn(valid[0]), .ReqReadyOut(ready[0]),
      .AddrIn(addr), .WDataIn(wd), .LoadIn(ld), .StoreIn(st), .SizeIn(sz), .SignedIn(sg),
      .MemAddrOut(memAddr[0]), .MemDataOut(memDO[0]), .MemReadOut(memRd[0]),
      .MemWriteOut(memWr[0]), .MemDataIn(memDI[0]), .RDataOut(rdata[0]),
      .RValidOut(rvld[0]), .ErrOut(errO[0]), .StallOut(stall[0]));

   mem_access_unit #(.ADDR_W(5), .RD_WAIT(2)) u_dut1 (
      .clkIn(clk), .resetIn(rstN), .ReqValidIn(valid[1]), .ReqReadyOut(ready[1]),
      .AddrIn(addr), .WDataIn(wd), .LoadIn(ld), .StoreIn(st), .SizeIn(sz), .SignedIn(sg),
      .MemAddrOut(memAddr[1]), .MemDataOut(memDO[1]), .MemReadOut(memRd[1]),
      .MemWriteOut(memWr[1]), .MemDataIn(memDI[1]), .RDataOut(rdata[1]),
      .RValidOut(rvld[1]), .ErrOut(errO[1]), .StallOut(stall[1]));

   function automatic logic [31:0] seed(input int i, input int j);
      return (32'h9E37_79B9 * (j + 1)) ^ (32'h0101_0101 * i);
   endfunction

   // The slow memory returns garbage until its third read cycle.
   assign memDI[0] = ram[0][memAddr[0][4:0]];
   assign memDI[1] = (memRd[1] && rdRun < 2) ? ~ram[1][memAddr[1][4:0]] : ram[1][memAddr[1][4:0]];

   always @(posedge clk) begin
      rdRun <= memRd[1] ? rdRun + 1 : 0;
      for (int i = 0; i < 2; i++) begin
         if (memInit) for (int j = 0; j < 32; j++) ram[i][j] <= seed(i, j);
         else if (memWr[i]) ram[i][memAddr[i][4:0]] <= memDO[i];
      end
   end

   task automatic model_req(input int inst, input logic l, s, input logic [1:0] z,
                            input logic g, input logic [31:0] a, w, output res_t e);
      int     n, base, rw;
      longint v;
      e = '0;
      e.ready0 = 1'b1;
      rw = (inst == 1) ? 2 : 0;
      n = (z == 2'd0) ? 1 : (z == 2'd1) ? 2 : 4;
      base = int'(a % 128);
      if (z == 2'd3 || (l && s) || (a % n) != 0) begin
         e.lat = 1; e.err = 1'b1; e.stallc = 1;
         return;
      end
      if (l) begin
         v = 0;
         for (int i = 0; i < n; i++) v += longint'(refB[inst][base + i]) << (8 * i);
         if (g && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
         e.rdata = v[31:0];
         e.rdc = rw + 1; e.lat = 2 + rw; e.raddr = base / 4;
      end else begin
         for (int i = 0; i < n; i++) refB[inst][base + i] = w[8 * i +: 8];
         v = 0;
         for (int i = 0; i < 4; i++) v += longint'(refB[inst][(base / 4) * 4 + i]) << (8 * i);
         e.wdata = v[31:0]; e.wrc = 1; e.waddr = base / 4;
         if (n == 4) e.lat = 2;
         else begin e.lat = 3 + rw; e.rdc = rw + 1; e.raddr = base / 4; end
      end
      e.stallc = e.lat;
   endtask

   task automatic run_req(input int inst, input logic l, s, input logic [1:0] z,
                          input logic g, input logic [31:0] a, w, output res_t o);
      o = '0;
      o.lat = -1;
      @(posedge clk); #1;
      ld = l; st = s; sz = z; sg = g; addr = a; wd = w; valid[inst] = 1'b1;
      @(negedge clk);
      o.ready0 = ready[inst];
      if (stall[inst]) o.stallc = 1;
      @(posedge clk); #1;
      valid[inst] = 1'b0; ld = 1'b0; st = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (stall[inst]) o.stallc = o.stallc + 1;
         if (memRd[inst]) begin o.rdc = o.rdc + 1; o.raddr = memAddr[inst]; end
         if (memWr[inst]) begin o.wrc = o.wrc + 1; o.waddr = memAddr[inst]; o.wdata = memDO[inst]; end
         if (rvld[inst]) begin o.lat = k; o.rdata = rdata[inst]; o.err = errO[inst]; break; end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({ready[i], rvld[i], stall[i], memRd[i], memWr[i], errO[i]} !== 6'b100000 ||
             memAddr[i] !== 32'd0 || memDO[i] !== 32'd0 || rdata[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got rdy/vld/stl/rd/wr/err=%b%b%b%b%b%b addr=%h dout=%h rdata=%h want 100000 and zeros",
                     i, ready[i], rvld[i], stall[i], memRd[i], memWr[i], errO[i], memAddr[i], memDO[i], rdata[i]);
         end
      end
   endtask

   task automatic test_store_word;
      res_t o, e;
      model_req(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, e);
      run_req(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, o);
      checks++;
      if (o.lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", o.lat); end
      checks++;
      if (o.wrc !== 1 || o.rdc !== 0 || o.waddr !== 32'd2 || o.wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_write: got wr=%0d rd=%0d addr=%h data=%h want 1 0 2 deadbeef", o.wrc, o.rdc, o.waddr, o.wdata);
      end
      @(negedge clk);
      checks++;
      if (ram[0][2] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram: got %h want deadbeef", ram[0][2]); end
   endtask

   task automatic test_loads;
      res_t o;
      run_req(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, o);
      checks++;
      if (o.rdata !== 32'hFFFFFFDE || o.lat !== 2) begin
         errors++; $display("FAIL lb_signed: got %h lat %0d want ffffffde lat 2", o.rdata, o.lat);
      end
      run_req(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, o);
      checks++;
      if (o.rdata !== 32'h000000DE) begin errors++; $display("FAIL lbu: got %h want 000000de", o.rdata); end
      run_req(0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h08, 32'h0, o);
      checks++;
      if (o.rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_signed: got %h want ffffbeef", o.rdata); end
      @(negedge clk);
      checks++;
      if (rdata[0] !== 32'hFFFFBEEF || rvld[0] !== 1'b0) begin
         errors++; $display("FAIL rdata_hold: got %h vld %b want ffffbeef vld 0", rdata[0], rvld[0]);
      end
   endtask

   task automatic test_rmw;
      res_t o, e;
      model_req(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h09, 32'h55, e);
      run_req(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h09, 32'h55, o);
      checks++;
      if (o.rdc !== 1 || o.wrc !== 1 || o.raddr !== 32'd2 || o.wdata !== 32'hDEAD55EF) begin
         errors++;
         $display("FAIL sb_rmw: got rd=%0d wr=%0d raddr=%h data=%h want 1 1 2 dead55ef", o.rdc, o.wrc, o.raddr, o.wdata);
      end
      checks++;
      if (o.stallc !== 3 || o.lat !== 3 || o.rdata !== 32'd0) begin
         errors++; $display("FAIL sb_timing: got stall=%0d lat=%0d rdata=%h want 3 3 0", o.stallc, o.lat, o.rdata);
      end
   endtask

   task automatic test_errors;
      res_t o;
      logic [31:0] ea [3];
      logic [1:0]  ez [3];
      logic        el [3];
      ea = '{32'h06, 32'h04, 32'h00};
      ez = '{2'd2, 2'd3, 2'd2};
      el = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         run_req(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, o);  // leaves RDataOut non-zero
         run_req(0, 1'b1, el[i], ez[i], 1'b0, ea[i], 32'h0, o);
         checks++;
         if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'd0 || o.rdc !== 0 || o.wrc !== 0) begin
            errors++;
            $display("FAIL err_req[%0d]: got lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 1 1 0 0 0",
                     i, o.lat, o.err, o.rdata, o.rdc, o.wrc);
         end
      end
   endtask

   task automatic test_rd_wait;
      res_t o, e;
      model_req(1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFEF00D, e);
      run_req(1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFEF00D, o);
      run_req(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, o);
      checks++;
      if (o.rdc !== 3 || o.lat !== 4 || o.stallc !== 4) begin
         errors++; $display("FAIL rdwait_timing: got rd=%0d lat=%0d stall=%0d want 3 4 4", o.rdc, o.lat, o.stallc);
      end
      checks++;
      if (o.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rdwait_data: got %h want cafef00d", o.rdata); end
   endtask

   task automatic test_idle_req;
      @(posedge clk); #1;
      ld = 1'b0; st = 1'b0; addr = 32'h10; valid[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (ready[0] !== 1'b1 || stall[0] !== 1'b0 || rvld[0] !== 1'b0 || memRd[0] !== 1'b0 || memWr[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_req[%0d]: got rdy=%b stall=%b vld=%b rd=%b wr=%b want 1 0 0 0 0",
                     k, ready[0], stall[0], rvld[0], memRd[0], memWr[0]);
         end
      end
      valid[0] = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      ld = 1'b0; st = 1'b1; sz = 2'd1; sg = 1'b0; addr = 32'h0A; wd = 32'h1234; valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0; st = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (memWr[0] !== 1'b1) begin errors++; $display("FAIL rstmid_inwr: got wr=%b want 1", memWr[0]); end
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (memWr[0] !== 1'b0 || memAddr[0] !== 32'd0 || ready[0] !== 1'b1 || stall[0] !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: got wr=%b addr=%h rdy=%b stall=%b want 0 0 1 0", memWr[0], memAddr[0], ready[0], stall[0]);
      end
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checks++;
      if (ram[0][2] !== 32'hDEAD55EF || rvld[0] !== 1'b0) begin
         errors++; $display("FAIL rstmid_mem: got %h vld %b want dead55ef vld 0", ram[0][2], rvld[0]);
      end
   endtask

   task automatic test_random;
      res_t        o, e;
      int          inst, op;
      logic        l, s, g;
      logic [1:0]  z;
      logic [31:0] a, w;
      for (int t = 0; t < 60; t++) begin
         inst = $urandom_range(0, 1);
         op   = $urandom_range(0, 9);
         l = (op <= 5);
         s = (op == 0) || (op > 5);
         z = 2'($urandom_range(0, 3));
         g = 1'($urandom_range(0, 1));
         a = $urandom;
         w = $urandom;
         if ($urandom_range(0, 3) != 0)
            a = (z == 2'd1) ? {a[31:1], 1'b0} : (z == 2'd2) ? {a[31:2], 2'b00} : a;
         model_req(inst, l, s, z, g, a, w, e);
         run_req(inst, l, s, z, g, a, w, o);
         checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", t, o.lat, e.lat); end
         checks++; if (o.err !== e.err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", t, o.err, e.err); end
         checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, o.rdata, e.rdata); end
         checks++; if (o.rdc !== e.rdc) begin errors++; $display("FAIL rand_rdcnt[%0d]: got %0d want %0d", t, o.rdc, e.rdc); end
         checks++; if (o.wrc !== e.wrc) begin errors++; $display("FAIL rand_wrcnt[%0d]: got %0d want %0d", t, o.wrc, e.wrc); end
         checks++; if (o.stallc !== e.stallc) begin errors++; $display("FAIL rand_stall[%0d]: got %0d want %0d", t, o.stallc, e.stallc); end
         checks++; if (o.raddr !== e.raddr) begin errors++; $display("FAIL rand_raddr[%0d]: got %h want %h", t, o.raddr, e.raddr); end
         checks++; if (o.waddr !== e.waddr) begin errors++; $display("FAIL rand_waddr[%0d]: got %h want %h", t, o.waddr, e.waddr); end
         checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rand_wdata[%0d]: got %h want %h", t, o.wdata, e.wdata); end
         checks++; if (o.ready0 !== e.ready0) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", t, o.ready0, e.ready0); end
      end
   endtask

   task automatic test_mem_contents;
      logic [31:0] ew;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 32; j++) begin
            ew = {refB[i][4*j+3], refB[i][4*j+2], refB[i][4*j+1], refB[i][4*j]};
            checks++;
            if (ram[i][j] !== ew) begin errors++; $display("FAIL mem_word[%0d][%0d]: got %h want %h", i, j, ram[i][j], ew); end
         end
      end
   endtask

   initial begin
      rstN = 1'b0; memInit = 1'b1;
      valid[0] = 1'b0; valid[1] = 1'b0;
      ld = 1'b0; st = 1'b0; sz = 2'd0; sg = 1'b0; addr = '0; wd = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 32; j++)
            for (int b = 0; b < 4; b++)
               refB[i][4*j+b] = 8'(seed(i, j) >> (8 * b));
      repeat (3) @(posedge clk);
      test_reset;
      memInit = 1'b0;
      rstN = 1'b1;
      test_store_word;
      test_loads;
      test_rmw;
      test_errors;
      test_rd_wait;
      test_idle_req;
      test_reset_mid;
      test_random;
      test_mem_contents;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
